// File: rtl/periph_apb_bridge.sv
// Purpose: uncached-port responder that decodes a 64KB peripheral window into 4KB APB slots.
// Latency: accept at T, SETUP T+1, first ACCESS T+2, response T+3 at zero wait; decode errors respond at T+1.
// Backpressure: one request in flight; req_ready_o only in IDLE, response held until resp_ready_i.
module periph_apb_bridge #(
  parameter int                      XLEN           = 32,
  parameter int                      NUM_SLOTS      = 16,
  parameter logic [XLEN-1:0]         BASE_ADDR      = 32'h2000_0000,
  parameter logic [NUM_SLOTS-1:0]    SLOT_EN        = 16'h23FF,
  parameter int                      TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // core-side request
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [XLEN-1:0]           req_addr_i,
  input  logic                      req_we_i,
  input  logic [XLEN-1:0]           req_wdata_i,
  input  logic [XLEN/8-1:0]         req_wstrb_i,
  // core-side response
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [XLEN-1:0]           resp_rdata_o,
  output logic                      resp_err_o,
  // APB-style peripheral side
  output logic [NUM_SLOTS-1:0]      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [11:0]               paddr_o,
  output logic [XLEN-1:0]           pwdata_o,
  output logic [XLEN/8-1:0]         pstrb_o,
  input  logic [NUM_SLOTS*XLEN-1:0] prdata_i,
  input  logic [NUM_SLOTS-1:0]      pready_i,
  input  logic [NUM_SLOTS-1:0]      pslverr_i
);

  localparam int              SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [XLEN-1:0] WIN_SIZE = XLEN'(NUM_SLOTS) << 12;
  localparam logic [XLEN-1:0] WIN_MASK = ~(WIN_SIZE - XLEN'(1));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched request: only the offset and slot index of the address are needed
  // after decode, the window check is resolved at accept time.
  logic [11:0]        paddr_q;
  logic [SLOT_W-1:0]  slot_q;
  logic               we_q;
  logic [XLEN-1:0]    wdata_q;
  logic [XLEN/8-1:0]  wstrb_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]    rdata_q;
  logic               err_q;

  // Decode of the incoming address (valid only while IDLE).
  logic [SLOT_W-1:0]  req_slot;
  logic               req_in_window;
  logic               req_ok;
  logic               accept;

  assign req_slot      = req_addr_i[12 +: SLOT_W];
  assign req_in_window = (req_addr_i & WIN_MASK) == BASE_ADDR;
  assign req_ok        = req_in_window && SLOT_EN[req_slot];
  assign accept        = (state_q == IDLE) && req_valid_i;

  // Selected-slot view of the peripheral return signals; other slots are ignored.
  logic               sel_ready;
  logic               sel_err;
  logic [XLEN-1:0]    sel_rdata;
  logic               timeout_hit;

  assign sel_ready   = pready_i[slot_q];
  assign sel_err     = pslverr_i[slot_q];
  assign sel_rdata   = prdata_i[slot_q*XLEN +: XLEN];
  assign timeout_hit = (cnt_q == CNT_LAST);

  // State register; reset aborts any transfer without producing a response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/control outputs decoded from the current state.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    penable_o    = 1'b0;
    psel_o       = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = req_ok ? SETUP : RESP;
        end
      end
      SETUP: begin
        psel_o  = NUM_SLOTS'(1) << slot_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_o    = NUM_SLOTS'(1) << slot_q;
        penable_o = 1'b1;
        if (sel_ready || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_q <= '0;
      slot_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            paddr_q <= req_addr_i[11:0];
            slot_q  <= req_slot;
            we_q    <= req_we_i;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
            // A decode failure goes straight to RESP with these values.
            err_q   <= !req_ok;
            rdata_q <= '0;
          end
        end
        SETUP: begin
          cnt_q <= '0;
        end
        ACCESS: begin
          if (sel_ready) begin
            err_q   <= sel_err;
            rdata_q <= (!we_q && !sel_err) ? sel_rdata : '0;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The data path is driven straight from the latched request, so it is
  // stable for the whole SETUP/ACCESS sequence.
  assign paddr_o      = paddr_q;
  assign pwrite_o     = we_q;
  assign pwdata_o     = wdata_q;
  assign pstrb_o      = wstrb_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: doc/periph_apb_bridge.md
Name: periph_apb_bridge

Overview:
- Responder side of the uncached peripheral path. Accepts single-outstanding word requests from the core's uncached port for the 0x2000_0000–0x2000_FFFF peripheral window.
- Decodes the request into one of sixteen 4KB APB-style slots and runs the SETUP/ACCESS handshake to the selected peripheral.
- Returns read data or an error response: error for an unimplemented slot, an out-of-window address, a slave error, or a timeout.
- Sits between the core's uncached memory interface and the UART/SPI/I2C/GPIO/PWM/Timer/PLIC/WDT/DMA/VGA-control peripherals.

Parameters:
- XLEN, 32, address/data width.
- NUM_SLOTS, 16, number of 4KB peripheral slots.
- BASE_ADDR, 32'h2000_0000, base of peripheral window; window size NUM_SLOTS*4KB.
- SLOT_EN, 16'h23FF, bit i=1 means slot i is implemented. Slots 0–9 and 13 are implemented; 10–12, 14 and 15 are reserved.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles waiting for pready before an error response.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  XLEN  byte address
- req_we_i  in  1  1=write, 0=read
- req_wdata_i  in  XLEN  write data
- req_wstrb_i  in  XLEN/8  byte strobes
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid&ready
- resp_rdata_o  out  XLEN  read data (0 on write or error)
- resp_err_o  out  1  access fault
- psel_o  out  NUM_SLOTS  one-hot slot select
- penable_o  out  1  APB access phase
- pwrite_o  out  1  write
- paddr_o  out  12  offset within slot
- pwdata_o  out  XLEN  write data
- pstrb_o  out  XLEN/8  strobes
- prdata_i  in  NUM_SLOTS*XLEN  per-slot read data, slot i at [i*XLEN +: XLEN]
- pready_i  in  NUM_SLOTS  per-slot ready
- pslverr_i  in  NUM_SLOTS  per-slot error

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - psel_o=0, penable_o=0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, timeout counter=0.
  - All captured request registers are cleared.
  - req_ready_o=1 after reset release.
  - Reset mid-transaction aborts it silently; no response is issued.
- req_ready_o=1 only in IDLE. Accepting a request latches addr, we, wdata and wstrb.
- Decode on accept:
  - in_window = (addr & ~(NUM_SLOTS*4096-1)) == BASE_ADDR.
  - slot = addr[15:12].
  - ok = in_window & SLOT_EN[slot].
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On accept with ok → SETUP.
  - On accept with !ok → RESP with err=1, rdata=0. No psel is driven.
- SETUP (one cycle):
  - psel_o[slot]=1, penable_o=0.
  - paddr_o=addr[11:0]; pwrite_o, pwdata_o and pstrb_o come from the latched request.
  - Timeout counter is cleared.
  - Next state is ACCESS.
- ACCESS:
  - psel held, penable_o=1.
  - If pready_i[slot]=1:
    - Capture err=pslverr_i[slot].
    - rdata = (!we & !pslverr) ? prdata slot : 0.
    - Go to RESP.
  - Else, if counter == TIMEOUT_CYCLES-1: go to RESP with err=1, rdata=0.
  - Else: counter+1.
  - pready_i from non-selected slots is ignored.
- RESP:
  - psel_o=0, penable_o=0, resp_valid_o=1.
  - rdata and err are held stable until resp_ready_i. On the handshake → IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Latency, with the accept at edge T:
  - SETUP in cycle T+1.
  - ACCESS first cycle in T+2.
  - With zero-wait pready, resp_valid_o rises in T+3.
  - Error-decoded requests: resp_valid_o in T+1.
- Data-path outputs: paddr_o, pwrite_o, pwdata_o and pstrb_o are held from the latched request and stay stable through SETUP and ACCESS. Values outside SETUP/ACCESS are don't-care.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It saturates at the limit and never wraps.
- Address bits [1:0] are passed through unchecked in paddr_o[1:0]. Alignment checking is done upstream.

Test Plan:
- Read 0x2000_4010 (GPIO), slot 4 pready=1 first ACCESS cycle, prdata=0xDEAD_BEEF → psel_o=16'h0010, paddr_o=0x010; resp_valid T+3, rdata=0xDEADBEEF, err=0.
- Write 0x2000_0004 with wdata=0x55, wstrb=4'b0001, UART0 pready delayed 3 cycles → penable high 4 cycles, pwdata/pstrb stable throughout; resp_rdata=0, err=0.
- Read 0x2000_A000 (reserved slot 10) → no psel ever asserted; resp_valid T+1, err=1, rdata=0. Same response for 0x2001_0000 (out of window).
- Read slot 13 (0x2000_D000) with pready=0 forever → exactly 255 ACCESS cycles, then psel drops, err=1.
- Slot 6 responds pready=1, pslverr=1 on a read → err=1, rdata=0. Hold resp_ready_i=0 for 5 cycles → response stable, req_ready_o=0 throughout.
- Assert rst_ni=0 during ACCESS → psel/penable drop immediately, no resp_valid; the next request completes normally.
